// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, bus size codes, FSM states.
package load_store_unit_pkg;

    // RV32I load funct3 codes
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // RV32I store funct3 codes
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Bus size codes, shared by dbc_size_in and dbc_size_out
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StDone  = 2'b10
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Combinational load-result extension: picks the byte/half/word from the bus word and
// sign- or zero-extends it according to funct3.
module lsu_load_extend
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    output logic [31:0] result
);

    // Extension select; the bus returns the addressed lane already in the low bits
    always_comb begin
        result = word;
        case (funct3)
            LB:      result = {{24{word[7]}}, word[7:0]};
            LH:      result = {{16{word[15]}}, word[15:0]};
            LW:      result = word;
            LBU:     result = {24'h000000, word[7:0]};
            LHU:     result = {16'h0000, word[15:0]};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: computes the effective address, screens for illegal/misaligned accesses,
// runs one bus transaction with a timeout and reports completion with optional write-back.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_idx,
    output logic        lsu_busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        wb_en,
    output logic [4:0]  wb_idx,
    output logic        misaligned,
    output logic        illegal,
    output logic        bus_error,
    output logic        dbc_wd,
    output logic        dbc_rd,
    output logic [1:0]  dbc_size_in,
    output logic [1:0]  dbc_size_out,
    output logic [31:0] dbc_addr_in,
    output logic [31:0] dbc_addr_out,
    output logic [31:0] dbc_data_in,
    input  logic [31:0] dbc_data_out,
    input  logic        dbc_ready,
    input  logic        dbc_busy
);

    lsu_state_e       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             is_store_q, is_store_d;
    logic [31:0]      sdata_q, sdata_d;
    logic [4:0]       rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      ldata_q, ldata_d;
    logic             mis_q, mis_d;
    logic             ill_q, ill_d;
    logic             berr_q, berr_d;

    logic [31:0] ea;
    logic        dec_illegal;
    logic        dec_misaligned;
    logic        handshake;
    logic [31:0] ext_word;

    assign ea          = base + offset;
    assign dec_illegal = (funct3[1:0] == 2'b11) | (is_store & funct3[2]);
    assign dec_misaligned = ((funct3[1:0] == SZ_HALF) & ea[0]) |
                            ((funct3[1:0] == SZ_WORD) & (ea[1:0] != 2'b00));
    assign handshake   = dbc_ready & ~dbc_busy;

    lsu_load_extend u_load_extend (
        .funct3 (funct3_q),
        .word   (dbc_data_out),
        .result (ext_word)
    );

    // Next-state and latch-enable logic for the request FSM
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        funct3_d   = funct3_q;
        is_store_d = is_store_q;
        sdata_d    = sdata_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        ldata_d    = ldata_q;
        mis_d      = mis_q;
        ill_d      = ill_q;
        berr_d     = berr_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d     = ea;
                    funct3_d   = funct3;
                    is_store_d = is_store;
                    sdata_d    = store_data;
                    rd_d       = rd_idx;
                    cnt_d      = '0;
                    ldata_d    = '0;
                    ill_d      = dec_illegal;
                    mis_d      = dec_misaligned;
                    berr_d     = 1'b0;
                    // Rejected requests skip the bus entirely
                    state_d    = (dec_illegal | dec_misaligned) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (handshake) begin
                    if (!is_store_q) begin
                        ldata_d = ext_word;
                    end
                    state_d = StDone;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    berr_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and latched-request registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            funct3_q   <= '0;
            is_store_q <= 1'b0;
            sdata_q    <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            ldata_q    <= '0;
            mis_q      <= 1'b0;
            ill_q      <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            funct3_q   <= funct3_d;
            is_store_q <= is_store_d;
            sdata_q    <= sdata_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            ldata_q    <= ldata_d;
            mis_q      <= mis_d;
            ill_q      <= ill_d;
            berr_q     <= berr_d;
        end
    end

    // Outputs decoded from the state register; idle bus fields are held at zero
    always_comb begin
        lsu_busy     = (state_q != StIdle);
        done         = (state_q == StDone);
        dbc_rd       = (state_q == StIssue) & ~is_store_q;
        dbc_wd       = (state_q == StIssue) & is_store_q;
        dbc_addr_out = dbc_rd ? addr_q : 32'h0;
        dbc_size_out = dbc_rd ? funct3_q[1:0] : 2'b00;
        dbc_addr_in  = dbc_wd ? addr_q : 32'h0;
        dbc_size_in  = dbc_wd ? funct3_q[1:0] : 2'b00;
        dbc_data_in  = dbc_wd ? sdata_q : 32'h0;
        load_data    = ldata_q;
        misaligned   = mis_q;
        illegal      = ill_q;
        bus_error    = berr_q;
        wb_idx       = rd_q;
        wb_en        = done & ~is_store_q & ~ill_q & ~mis_q & ~berr_q & (rd_q != 5'd0);
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the data bus controller.
- Takes one load/store request per transaction (funct3, base, offset, store data, destination register).
- Computes the effective address, checks alignment, drives the bus read/write strobes, size codes and addresses, and waits for the bus handshake.
- For loads, sign- or zero-extends the returned data and produces a register write-back pulse.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in ISSUE waiting for the bus before raising bus_error.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request strobe; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- funct3  in  3  RV32I load/store funct3
- base  in  32  rs1 value
- offset  in  32  sign-extended immediate
- store_data  in  32  rs2 value
- rd_idx  in  5  load destination register
- lsu_busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- load_data  out  32  extended load result; valid while done=1
- wb_en  out  1  register write enable; equals done for a successful load with rd_idx≠0
- wb_idx  out  5  latched rd_idx
- misaligned  out  1  valid with done
- illegal  out  1  valid with done
- bus_error  out  1  valid with done
- dbc_wd  out  1  bus write strobe
- dbc_rd  out  1  bus read strobe
- dbc_size_in  out  2  store size (00 byte, 01 half, 10 word)
- dbc_size_out  out  2  load size (same coding)
- dbc_addr_in  out  32  store address
- dbc_addr_out  out  32  load address
- dbc_data_in  out  32  store data
- dbc_data_out  in  32  zero-extended read data from the bus
- dbc_ready  in  1  bus ready
- dbc_busy  in  1  bus busy

Behaviour:
- Reset: state=IDLE; all outputs 0; timeout counter 0.
- Reset mid-operation: rst overrides everything. Strobes drop at the next edge and no done pulse is produced.
- IDLE, start=1:
  - Latch addr = base+offset (mod 2^32, carry discarded), size=funct3[1:0], sign=~funct3[2], is_store, store_data, rd_idx.
  - Decode checks, evaluated on the unlatched inputs:
    - illegal = (funct3[1:0]==11) | (is_store & funct3[2]).
    - misaligned = (size==01 & addr[0]) | (size==10 & addr[1:0]≠00).
  - If illegal or misaligned: go to DONE with no bus access; the flag is reported with done.
  - Otherwise: go to ISSUE.
- ISSUE:
  - Load drives dbc_rd=1. Store drives dbc_wd=1.
  - dbc_rd and dbc_wd are never both high.
  - The unused address and size outputs are driven to 0. Addresses are forwarded unchanged.
  - dbc_data_in = store_data, unmodified; the bus merges sub-word lanes.
  - Handshake completes in the cycle where dbc_ready & ~dbc_busy. In that cycle the load data is captured from dbc_data_out and the store is committed at the edge. Then go to DONE.
  - The counter increments each cycle without handshake. Reaching TIMEOUT_CYCLES sets bus_error and goes to DONE.
- Load extension (from the captured word):
  - 000: sign-extend [7:0]
  - 001: sign-extend [15:0]
  - 010: full word
  - 100: zero-extend [7:0]
  - 101: zero-extend [15:0]
- DONE:
  - done=1 for exactly one cycle; the flags are valid.
  - wb_en=1 only for a load with no error and rd_idx≠0.
  - Return to IDLE and clear the counter.
- Latency: start at cycle 0, ISSUE at cycle 1. With an immediate handshake, done is high in cycle 2. Error short-circuit: done in cycle 1.
- start outside IDLE is ignored; the upstream stage stalls on lsu_busy.
- Outputs are registered from state, except load_data/flags, which are latched.

Decomposition:
- Shared package/header (next to the memory map defines) holds:
  - funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW)
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state encodings IDLE/ISSUE/DONE
- One natural sub-module: lsu_load_extend, a combinational funct3 + word → 32-bit result.

Test Plan:
- Load LB: base=0x10, offset=0, funct3=000, bus returns 0x000000F0 with immediate ready -> dbc_rd high in cycle 1, addr_out=0x10, size_out=00; done in cycle 2 with load_data=0xFFFFFFF0, wb_en=1, wb_idx latched.
- Store SW: base=0x20, offset=4, data=0xDEADBEEF -> dbc_wd=1, addr_in=0x24, size_in=10, data_in=0xDEADBEEF for one cycle; done with wb_en=0.
- Misaligned LW at 0x22 -> no dbc_rd/dbc_wd; done in cycle 1 with misaligned=1, wb_en=0.
- Illegal funct3=011 load and SB with funct3=100 -> illegal=1, no bus strobe.
- dbc_busy held 3 cycles -> dbc_rd held 4 cycles, done in cycle 5. dbc_busy held 20 cycles with TIMEOUT_CYCLES=16 -> bus_error=1 at done.
- rst asserted in ISSUE -> next cycle all strobes 0, state IDLE, no done. LHU of 0x0000ABCD -> load_data=0x0000ABCD.
